// File: rtl/vslc_pkg.sv
// rtl/vslc_pkg.sv - shared constants and types for the VSLC timer configuration front end
package vslc_pkg;

    localparam int PERIOD_W_DEF = 10;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LDA  = 2'b01;
    localparam logic [1:0] OP_LDB  = 2'b10;
    localparam logic [1:0] OP_CTRL = 2'b11;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_COMMIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO_A = 3'd1,
        ST_HI_A = 3'd2,
        ST_LO_B = 3'd3,
        ST_HI_B = 3'd4
    } cfg_state_e;

endpackage

// File: rtl/vslc_cfg_shadow.sv
// rtl/vslc_cfg_shadow.sv - shadow/active register bundle for periods A, B and enable, with commit timing
module vslc_cfg_shadow
    import vslc_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          wr_byte,
    input  logic                we_a_lo,
    input  logic                we_a_hi,
    input  logic                we_b_lo,
    input  logic                we_b_hi,
    input  logic                we_en,
    input  logic                commit_req,
    input  logic [PERIOD_W-1:0] timer_counter_w,
    output logic [PERIOD_W-1:0] period_a,
    output logic [PERIOD_W-1:0] period_b,
    output logic                enabled,
    output logic                commit_pending
);

    logic [PERIOD_W-1:0] shadow_a_q, shadow_a_d;
    logic [PERIOD_W-1:0] shadow_b_q, shadow_b_d;
    logic                shadow_en_q, shadow_en_d;
    logic [PERIOD_W-1:0] active_a_q, active_a_d;
    logic [PERIOD_W-1:0] active_b_q, active_b_d;
    logic                active_en_q, active_en_d;
    logic                pending_q, pending_d;
    logic                commit_fire;

    // A running timer is only reloaded as it wraps through zero.
    assign commit_fire = pending_q && (!active_en_q || (timer_counter_w == '0));

    always_comb begin
        shadow_a_d  = shadow_a_q;
        shadow_b_d  = shadow_b_q;
        shadow_en_d = shadow_en_q;
        active_a_d  = active_a_q;
        active_b_d  = active_b_q;
        active_en_d = active_en_q;
        pending_d   = pending_q;

        if (we_a_lo) shadow_a_d[7:0]          = wr_byte;
        if (we_a_hi) shadow_a_d[PERIOD_W-1:8] = wr_byte[PERIOD_W-9:0];
        if (we_b_lo) shadow_b_d[7:0]          = wr_byte;
        if (we_b_hi) shadow_b_d[PERIOD_W-1:8] = wr_byte[PERIOD_W-9:0];
        if (we_en)   shadow_en_d              = wr_byte[CTRL_EN];

        if (commit_fire) begin
            active_a_d  = shadow_a_q;
            active_b_d  = shadow_b_q;
            active_en_d = shadow_en_q;
            pending_d   = 1'b0;
        end
        if (commit_req) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_a_q  <= '0;
            shadow_b_q  <= '0;
            shadow_en_q <= 1'b0;
            active_a_q  <= '0;
            active_b_q  <= '0;
            active_en_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            shadow_a_q  <= shadow_a_d;
            shadow_b_q  <= shadow_b_d;
            shadow_en_q <= shadow_en_d;
            active_a_q  <= active_a_d;
            active_b_q  <= active_b_d;
            active_en_q <= active_en_d;
            pending_q   <= pending_d;
        end
    end

    assign period_a       = active_a_q;
    assign period_b       = active_b_q;
    assign enabled        = active_en_q;
    assign commit_pending = pending_q;

endmodule

// File: rtl/vslc_timer_cfg.sv
// rtl/vslc_timer_cfg.sv - byte-serial configuration front end feeding the VSLC timer
module vslc_timer_cfg
    import vslc_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    input  logic [7:0]          wr_data,
    output logic                wr_ready,
    input  logic [PERIOD_W-1:0] timer_counter_w,
    output logic [PERIOD_W-1:0] timer_period_a,
    output logic [PERIOD_W-1:0] timer_period_b,
    output logic                timer_enabled,
    output logic                commit_pending,
    output logic                cfg_err,
    input  logic                clr_err
);

    localparam logic [7:0] HI_MASK = 8'((1 << (PERIOD_W - 8)) - 1);

    cfg_state_e state_q, state_d;
    logic       cfg_err_q, cfg_err_d;
    logic       accept;
    logic       new_err;
    logic       we_a_lo, we_a_hi, we_b_lo, we_b_hi, we_en, commit_req;

    assign wr_ready = !commit_pending;
    assign accept   = wr_valid && wr_ready;

    always_comb begin
        state_d    = state_q;
        new_err    = 1'b0;
        we_a_lo    = 1'b0;
        we_a_hi    = 1'b0;
        we_b_lo    = 1'b0;
        we_b_hi    = 1'b0;
        we_en      = 1'b0;
        commit_req = 1'b0;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    case (wr_data[7:6])
                        OP_LDA:  state_d = ST_LO_A;
                        OP_LDB:  state_d = ST_LO_B;
                        OP_CTRL: begin
                            we_en      = 1'b1;
                            commit_req = wr_data[CTRL_COMMIT];
                            new_err    = |wr_data[5:2];
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                ST_LO_A: begin
                    we_a_lo = 1'b1;
                    state_d = ST_HI_A;
                end
                ST_HI_A: begin
                    we_a_hi = 1'b1;
                    new_err = |(wr_data & ~HI_MASK);
                    state_d = ST_IDLE;
                end
                ST_LO_B: begin
                    we_b_lo = 1'b1;
                    state_d = ST_HI_B;
                end
                ST_HI_B: begin
                    we_b_hi = 1'b1;
                    new_err = |(wr_data & ~HI_MASK);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A fresh error outranks a simultaneous clear.
        cfg_err_d = (clr_err ? 1'b0 : cfg_err_q) | new_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    vslc_cfg_shadow #(
        .PERIOD_W(PERIOD_W)
    ) u_shadow (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_byte        (wr_data),
        .we_a_lo        (we_a_lo),
        .we_a_hi        (we_a_hi),
        .we_b_lo        (we_b_lo),
        .we_b_hi        (we_b_hi),
        .we_en          (we_en),
        .commit_req     (commit_req),
        .timer_counter_w(timer_counter_w),
        .period_a       (timer_period_a),
        .period_b       (timer_period_b),
        .enabled        (timer_enabled),
        .commit_pending (commit_pending)
    );

endmodule

// File: tb/tb_vslc_timer_cfg.sv
// tb/tb_vslc_timer_cfg.sv - self-checking bench for vslc_timer_cfg against a frame-level reference model
module tb_vslc_timer_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [9:0] timer_counter_w;
    logic [9:0] timer_period_a;
    logic [9:0] timer_period_b;
    logic       timer_enabled;
    logic       commit_pending;
    logic       cfg_err;
    logic       clr_err;

    int total = 0;
    int bad   = 0;

    // Reference model: which period a frame targets (0 none, 1 A, 2 B) and how many data bytes seen.
    int m_tgt, m_nbytes;
    int m_sh_a, m_sh_b, m_sh_en;
    int m_act_a, m_act_b, m_act_en;
    int m_pend, m_err;

    always #5 clk = ~clk;

    vslc_timer_cfg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .timer_counter_w(timer_counter_w),
        .timer_period_a (timer_period_a),
        .timer_period_b (timer_period_b),
        .timer_enabled  (timer_enabled),
        .commit_pending (commit_pending),
        .cfg_err        (cfg_err),
        .clr_err        (clr_err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tgt = 0; m_nbytes = 0;
        m_sh_a = 0; m_sh_b = 0; m_sh_en = 0;
        m_act_a = 0; m_act_b = 0; m_act_en = 0;
        m_pend = 0; m_err = 0;
    endtask

    task automatic model_step(input int v, input int d, input int c, input int clr);
        int take, fire, set_pend, e, val;
        take = (v != 0) && (m_pend == 0);
        fire = (m_pend != 0) && (m_act_en == 0 || c == 0);
        set_pend = 0;
        e = 0;
        if (take) begin
            if (m_tgt == 0) begin
                if (d / 64 == 1) begin m_tgt = 1; m_nbytes = 0; end
                else if (d / 64 == 2) begin m_tgt = 2; m_nbytes = 0; end
                else if (d / 64 == 3) begin
                    m_sh_en  = d % 2;
                    set_pend = (d / 2) % 2;
                    e        = ((d / 4) % 16) != 0;
                end
            end else begin
                val = (m_tgt == 1) ? m_sh_a : m_sh_b;
                if (m_nbytes == 0) val = (val / 256) * 256 + d;
                else begin
                    val = (d % 4) * 256 + (val % 256);
                    e   = d >= 4;
                end
                if (m_tgt == 1) m_sh_a = val; else m_sh_b = val;
                m_nbytes++;
                if (m_nbytes == 2) m_tgt = 0;
            end
        end
        if (fire) begin
            m_act_a = m_sh_a; m_act_b = m_sh_b; m_act_en = m_sh_en;
            m_pend = 0;
        end
        if (set_pend) m_pend = 1;
        m_err = (clr != 0 ? 0 : m_err) | e;
    endtask

    task automatic check_all();
        chk("wr_ready",       int'(wr_ready),       m_pend == 0);
        chk("period_a",       int'(timer_period_a), m_act_a);
        chk("period_b",       int'(timer_period_b), m_act_b);
        chk("enabled",        int'(timer_enabled),  m_act_en);
        chk("commit_pending", int'(commit_pending), m_pend);
        chk("cfg_err",        int'(cfg_err),        m_err);
    endtask

    task automatic cyc(input int v, input int d, input int c, input int clr);
        wr_valid        = v[0];
        wr_data         = d[7:0];
        timer_counter_w = c[9:0];
        clr_err         = clr[0];
        model_step(v, d, c, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int r, d;
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_data = 8'h00; timer_counter_w = '0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_ready", int'(wr_ready), 1);
        rst_n = 1'b1;

        cyc(1, 'h40, 0, 0); cyc(1, 'h2C, 0, 0); cyc(1, 'h01, 0, 0);
        cyc(1, 'h80, 0, 0); cyc(1, 'h05, 0, 0); cyc(1, 'h00, 0, 0);
        cyc(1, 'hC3, 0, 0);
        chk("t1_pending_set", int'(commit_pending), 1);
        cyc(0, 0, 0, 0);
        chk("t1_period_a", int'(timer_period_a), 300);
        chk("t1_period_b", int'(timer_period_b), 5);
        chk("t1_enabled",  int'(timer_enabled), 1);
        chk("t1_pending",  int'(commit_pending), 0);
        chk("t1_err",      int'(cfg_err), 0);

        cyc(1, 'h40, 7, 0); cyc(1, 'h03, 7, 0); cyc(1, 'h00, 7, 0);
        cyc(1, 'hC3, 7, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 'h00, 7, 0);
            chk("t2_stall_ready", int'(wr_ready), 0);
            chk("t2_stall_a", int'(timer_period_a), 300);
        end
        cyc(1, 'h00, 0, 0);
        chk("t2_commit_a", int'(timer_period_a), 3);
        chk("t2_ready_back", int'(wr_ready), 1);
        cyc(0, 0, 5, 0);

        cyc(1, 'h40, 5, 0); cyc(1, 'h10, 5, 0); cyc(1, 'h04, 5, 0);
        chk("t3_err_set", int'(cfg_err), 1);
        cyc(0, 0, 5, 0);
        chk("t3_err_sticky", int'(cfg_err), 1);
        cyc(1, 'hC3, 0, 0); cyc(0, 0, 0, 0);
        chk("t3_shadow_a", int'(timer_period_a), 'h010);
        cyc(0, 0, 3, 1);
        chk("t3_err_clr", int'(cfg_err), 0);
        cyc(1, 'hC5, 3, 1);
        chk("t3_err_wins", int'(cfg_err), 1);
        cyc(0, 0, 3, 1);

        cyc(1, 'h00, 3, 0); cyc(1, 'hC0, 3, 0);
        chk("t5_pending", int'(commit_pending), 0);
        chk("t5_enabled", int'(timer_enabled), 1);
        chk("t5_ready",   int'(wr_ready), 1);

        cyc(1, 'hC2, 5, 0);
        chk("t6_pending", int'(commit_pending), 1);
        cyc(0, 0, 0, 0);
        chk("t6_done",    int'(commit_pending), 0);
        chk("t6_enabled", int'(timer_enabled), 0);

        cyc(1, 'h40, 0, 0); cyc(1, 'hFF, 0, 0);
        wr_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        cyc(1, 'hC2, 0, 0); cyc(0, 0, 0, 0);
        chk("t4_period_a", int'(timer_period_a), 0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      d = 'hC0 | $urandom_range(0, 3);
            else if (r < 4) d = 'h40 * $urandom_range(0, 3);
            else            d = $urandom_range(0, 255);
            if (r == 9 && $urandom_range(0, 1) == 0) d = d & 'h03;
            cyc(($urandom_range(0, 9) < 7) ? 1 : 0, d, $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
